// File: rtl/eeprom_pkg.sv
// Shared definitions for the EEPROM page-programming model.
//   - Default values of the block parameters (byte width, address width,
//     page size exponent, write-cycle time).
//   - Controller state type.
package eeprom_pkg;

  localparam int unsigned DefDataW  = 8;    // byte width
  localparam int unsigned DefAddrW  = 16;   // array address width (2^16 bytes)
  localparam int unsigned DefPageW  = 6;    // log2 page size (64 bytes)
  localparam int unsigned DefTwrCyc = 500;  // post-program write-cycle time in clk cycles

  // IDLE: no page open; LOAD: page buffer being filled;
  // PROG: buffer being copied into the array; WAIT: write-cycle time.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StProg = 2'd2,
    StWait = 2'd3
  } state_e;

endpackage

// File: rtl/eeprom_page_ram_if.sv
// Access bus of eeprom_page_ram.
//   a_req/a_wen/a_addr/a_din : one access per cycle (a_wen=1 buffer write, 0 read)
//   a_commit/wp              : start page programming, write protect sampled at commit
//   a_dout/a_dvld            : read data and its one-cycle valid pulse
//   busy                     : high while programming or in the write-cycle time
//   a_err                    : one-cycle pulse for a rejected request or commit
// master = requester side, slave = memory side.
interface eeprom_page_ram_if #(
  parameter int unsigned DATA_W = eeprom_pkg::DefDataW,
  parameter int unsigned ADDR_W = eeprom_pkg::DefAddrW
) ();

  logic              a_req;
  logic              a_wen;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_din;
  logic              a_commit;
  logic              wp;
  logic [DATA_W-1:0] a_dout;
  logic              a_dvld;
  logic              busy;
  logic              a_err;

  modport master (
    output a_req,
    output a_wen,
    output a_addr,
    output a_din,
    output a_commit,
    output wp,
    input  a_dout,
    input  a_dvld,
    input  busy,
    input  a_err
  );

  modport slave (
    input  a_req,
    input  a_wen,
    input  a_addr,
    input  a_din,
    input  a_commit,
    input  wp,
    output a_dout,
    output a_dvld,
    output busy,
    output a_err
  );

endinterface

// File: rtl/eeprom_array.sv
// Byte array of the EEPROM: single-port synchronous RAM.
//   clk_i   : clock, rising edge
//   en_i    : port enable (read or write this cycle)
//   we_i    : 1 = write wdata_i to addr_i, 0 = read addr_i
//   addr_i  : byte address
//   wdata_i : write data
//   rdata_o : read data, valid the cycle after a read, held until the next read
// Contents are never reset.
module eeprom_array
  import eeprom_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/eeprom_page_ram.sv
// EEPROM-style page RAM.
// Writes are collected into a one-page buffer (with a valid bit per slot);
// a commit copies the valid slots into the array one slot per cycle, then a
// fixed write-cycle time elapses before the block accepts requests again.
// Reads always come from the array, one cycle after the request.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : access bus (slave side), see eeprom_page_ram_if
module eeprom_page_ram
  import eeprom_pkg::*;
#(
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned PAGE_W  = DefPageW,
  parameter int unsigned TWR_CYC = DefTwrCyc
) (
  input logic              clk,
  input logic              rst,
  eeprom_page_ram_if.slave bus
);

  localparam int unsigned PageSize = 2**PAGE_W;
  localparam int unsigned BaseW    = ADDR_W - PAGE_W;
  localparam int unsigned CntW     = (TWR_CYC > 1) ? $clog2(TWR_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TWR_CYC - 1);

  // Controller state
  state_e              state_q, state_d;
  logic [BaseW-1:0]    base_q, base_d;    // page base latched by the first buffer write
  logic [PAGE_W-1:0]   slot_q, slot_d;    // PROG scan position
  logic [CntW-1:0]     cnt_q, cnt_d;      // WAIT cycle counter
  logic [PageSize-1:0] valid_q, valid_d;  // one bit per buffered slot

  // Page buffer data; only the valid bits need a reset.
  logic [DATA_W-1:0]   page_q [PageSize];

  // Output registers
  logic dvld_q;
  logic err_q, err_d;
  logic dout_zero_q;  // forces a_dout to 0 from reset until the first read

  // Decoded requests and datapath controls
  logic              rd_req;
  logic              wr_req;
  logic              busy;
  logic              rd_en;
  logic              buf_we;
  logic              prog_we;
  logic [PAGE_W-1:0] wr_slot;
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  assign rd_req  = bus.a_req & ~bus.a_wen;
  assign wr_req  = bus.a_req & bus.a_wen;
  assign wr_slot = bus.a_addr[PAGE_W-1:0];
  assign busy    = (state_q == StProg) || (state_q == StWait);

  // Next-state and control decode
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    rd_en   = 1'b0;
    buf_we  = 1'b0;
    prog_we = 1'b0;

    unique case (state_q)
      StIdle: begin
        rd_en = rd_req;
        // A commit with nothing buffered is silently ignored.
        if (wr_req) begin
          base_d           = bus.a_addr[ADDR_W-1:PAGE_W];
          buf_we           = 1'b1;
          valid_d[wr_slot] = 1'b1;
          state_d          = StLoad;
        end
      end

      StLoad: begin
        rd_en = rd_req;
        // Upper address bits are ignored here: writes wrap within the open page.
        if (wr_req) begin
          buf_we           = 1'b1;
          valid_d[wr_slot] = 1'b1;
        end
        if (bus.a_commit) begin
          if (bus.wp) begin
            // Clearing after the write above drops a same-cycle write as well.
            valid_d = '0;
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            slot_d  = '0;
            state_d = StProg;
          end
        end
      end

      StProg: begin
        err_d   = bus.a_req | bus.a_commit;
        prog_we = valid_q[slot_q];
        slot_d  = slot_q + 1'b1;
        if (slot_q == {PAGE_W{1'b1}}) begin
          cnt_d   = '0;
          state_d = StWait;
        end
      end

      StWait: begin
        err_d = bus.a_req | bus.a_commit;
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          valid_d = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Reads never overlap PROG (they are rejected while busy), so the port needs
  // no arbitration beyond this select. Gating with rst keeps the slot being
  // programmed during a reset cycle out of the array.
  assign ram_en   = (rd_en | prog_we) & ~rst;
  assign ram_addr = prog_we ? {base_q, slot_q} : bus.a_addr;

  eeprom_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk_i  (clk),
    .en_i   (ram_en),
    .we_i   (prog_we),
    .addr_i (ram_addr),
    .wdata_i(page_q[slot_q]),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      base_q      <= '0;
      slot_q      <= '0;
      cnt_q       <= '0;
      valid_q     <= '0;
      dvld_q      <= 1'b0;
      err_q       <= 1'b0;
      dout_zero_q <= 1'b1;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      dvld_q  <= rd_en;
      err_q   <= err_d;
      if (rd_en) begin
        dout_zero_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) begin
      page_q[wr_slot] <= bus.a_din;
    end
  end

  assign bus.a_dout = dout_zero_q ? '0 : ram_rdata;
  assign bus.a_dvld = dvld_q;
  assign bus.busy   = busy;
  assign bus.a_err  = err_q;

endmodule

// File: tb/tb_eeprom_page_ram.sv
// Directed bench for eeprom_page_ram (DATA_W=8, ADDR_W=16, PAGE_W=6, TWR_CYC=500).
module tb_eeprom_page_ram;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  eeprom_page_ram_if #(.DATA_W(8), .ADDR_W(16)) bus ();

  eeprom_page_ram #(
    .DATA_W (8),
    .ADDR_W (16),
    .PAGE_W (6),
    .TWR_CYC(500)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.a_req    = 1'b0;
    bus.a_wen    = 1'b0;
    bus.a_addr   = '0;
    bus.a_din    = '0;
    bus.a_commit = 1'b0;
    bus.wp       = 1'b0;
  endtask

  task automatic buf_write(input logic [15:0] addr, input logic [7:0] data);
    bus.a_req  = 1'b1;
    bus.a_wen  = 1'b1;
    bus.a_addr = addr;
    bus.a_din  = data;
    tick();
    bus.a_req  = 1'b0;
    bus.a_wen  = 1'b0;
  endtask

  task automatic commit(input logic prot);
    bus.a_commit = 1'b1;
    bus.wp       = prot;
    tick();
    bus.a_commit = 1'b0;
    bus.wp       = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check_eq({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic program_page(input string tag);
    commit(1'b0);
    wait_idle(tag);
  endtask

  task automatic read_chk(input string tag, input logic [15:0] addr, input logic [7:0] exp);
    bus.a_req  = 1'b1;
    bus.a_wen  = 1'b0;
    bus.a_addr = addr;
    tick();
    bus.a_req  = 1'b0;
    check_eq({tag, "_dvld"}, {31'd0, bus.a_dvld}, 32'd1);
    check_eq({tag, "_dout"}, {24'd0, bus.a_dout}, {24'd0, exp});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cnt;
    logic [7:0]  exp;
    logic [15:0] addr;

    idle_in();
    rst = 1'b1;
    repeat (3) tick();
    check_eq("rst_dout", {24'd0, bus.a_dout}, 32'd0);
    check_eq("rst_dvld", {31'd0, bus.a_dvld}, 32'd0);
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_err", {31'd0, bus.a_err}, 32'd0);
    rst = 1'b0;
    tick();

    // Commit with nothing buffered
    commit(1'b0);
    check_eq("idle_commit_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("idle_commit_err", {31'd0, bus.a_err}, 32'd0);

    // Read after program
    buf_write(16'h0100, 8'hA5);
    commit(1'b0);
    check_eq("commit_busy_rise", {31'd0, bus.busy}, 32'd1);
    wait_idle("rap");
    read_chk("rap_0100", 16'h0100, 8'hA5);
    tick();
    check_eq("dvld_pulse", {31'd0, bus.a_dvld}, 32'd0);
    check_eq("dout_hold", {24'd0, bus.a_dout}, 32'h0000_00A5);

    // Read in LOAD returns the array, not the buffer
    buf_write(16'h0100, 8'h3C);
    read_chk("load_rd", 16'h0100, 8'hA5);
    program_page("load");
    read_chk("load_after", 16'h0100, 8'h3C);

    // Wrap within the latched page
    buf_write(16'h01BF, 8'h33);
    program_page("wrap_prep");
    buf_write(16'h0140, 8'h11);
    buf_write(16'h01BF, 8'h22);
    program_page("wrap");
    read_chk("wrap_0140", 16'h0140, 8'h11);
    read_chk("wrap_017F", 16'h017F, 8'h22);
    read_chk("wrap_01BF", 16'h01BF, 8'h33);

    // Busy timing, read while busy
    buf_write(16'h0400, 8'h42);
    commit(1'b0);
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 2000) begin
      if (cnt == 100) begin
        bus.a_req  = 1'b1;
        bus.a_wen  = 1'b0;
        bus.a_addr = 16'h0400;
      end
      tick();
      cnt++;
      if (cnt == 101) begin
        bus.a_req = 1'b0;
        check_eq("busy_rd_err", {31'd0, bus.a_err}, 32'd1);
        check_eq("busy_rd_dvld", {31'd0, bus.a_dvld}, 32'd0);
      end
      if (cnt == 102) begin
        check_eq("busy_err_pulse", {31'd0, bus.a_err}, 32'd0);
      end
    end
    check_eq("busy_cycles", cnt, 32'd564);
    read_chk("busy_0400", 16'h0400, 8'h42);

    // Write protect
    buf_write(16'h0000, 8'h5A);
    program_page("wp_prep");
    buf_write(16'h0000, 8'h55);
    commit(1'b1);
    check_eq("wp_err", {31'd0, bus.a_err}, 32'd1);
    check_eq("wp_busy", {31'd0, bus.busy}, 32'd0);
    tick();
    check_eq("wp_err_pulse", {31'd0, bus.a_err}, 32'd0);
    check_eq("wp_busy2", {31'd0, bus.busy}, 32'd0);
    read_chk("wp_0000", 16'h0000, 8'h5A);
    buf_write(16'h0001, 8'h66);
    program_page("wp_post");
    read_chk("wp_post_0000", 16'h0000, 8'h5A);
    read_chk("wp_post_0001", 16'h0001, 8'h66);

    // Buffer write in the same cycle as commit
    buf_write(16'h0200, 8'h01);
    bus.a_req    = 1'b1;
    bus.a_wen    = 1'b1;
    bus.a_addr   = 16'h0203;
    bus.a_din    = 8'h77;
    bus.a_commit = 1'b1;
    tick();
    idle_in();
    check_eq("sim_busy", {31'd0, bus.busy}, 32'd1);
    wait_idle("sim");
    read_chk("sim_0203", 16'h0203, 8'h77);
    read_chk("sim_0200", 16'h0200, 8'h01);

    // Reset during PROG at slot 10
    for (int i = 0; i < 64; i++) begin
      buf_write(16'h0300 + 16'(i), 8'h80 + 8'(i));
    end
    program_page("rp_prep");
    for (int i = 0; i < 64; i++) begin
      buf_write(16'h0300 + 16'(i), 8'hC0 + 8'(i));
    end
    commit(1'b0);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rp_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rp_dout", {24'd0, bus.a_dout}, 32'd0);
    for (int i = 0; i < 64; i++) begin
      addr = 16'h0300 + 16'(i);
      exp  = (i < 10) ? 8'hC0 + 8'(i) : 8'h80 + 8'(i);
      read_chk($sformatf("rp_slot%0d", i), addr, exp);
    end
    // Valid bits were cleared by reset: only the new slot is programmed.
    buf_write(16'h0314, 8'h99);
    program_page("rp_post");
    read_chk("rp_post_0314", 16'h0314, 8'h99);
    read_chk("rp_post_031E", 16'h031E, 8'h9E);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
